fetch_sequencer: RTL and testbench

- Program-counter and fetch controller that drives the instruction ROM address port and sequences program execution.
- Holds the PC and presents the ROM word to the decode stage with a valid flag.
- Detects the halt word (all ones) and stops.
- Applies branch redirects from the datapath, supports stall, and runs a Start/Done handshake with the top-level test harness.

---
 rtl/fetch_sequencer.sv | 125 ++++++++++++
 tb/tb_fetch_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// ============================================================================
//  Module   : fetch_sequencer
//  Brief    : PC / fetch controller with halt detect, branch redirect, stall
//             and Start/Done handshake. Optional retire counter enabled by
//             defining FETCH_RETIRE_COUNT_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_sequencer #(
   parameter int unsigned A        = 12,
   parameter int unsigned W        = 10,
   parameter int unsigned START_PC = 0
) (
   input  logic         CLK,
   input  logic         Reset_n,
   input  logic         Start,
   input  logic         Stall,
   input  logic         BranchEn,
   input  logic         BranchAbs,
   input  logic [A-1:0] Target,
   input  logic [W-1:0] InstIn,
   output logic [A-1:0] InstAddress,
   output logic [W-1:0] InstOut,
   output logic         InstValid,
   output logic         Done
`ifdef FETCH_RETIRE_COUNT_EN
   ,
   output logic [15:0]  RetireCount
`endif
);

   localparam logic [A-1:0] c_START_PC = A'(START_PC);
   localparam logic [W-1:0] c_HALT     = {W{1'b1}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t       state_q, state_d;
   logic [A-1:0] pc_q, pc_d;
   logic         done_q, done_d;

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         pc_q    <= c_START_PC;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      done_d    = done_q;
      InstValid = 1'b0;
      case (state_q)
         IDLE, HALTED: begin
            if (Start) begin
               state_d = RUN;
               pc_d    = c_START_PC;
               done_d  = 1'b0;
            end
         end
         RUN: begin
            InstValid = ~Stall;
            // Stall freezes everything, including a pending halt or branch.
            if (!Stall) begin
               if (InstIn == c_HALT) begin
                  state_d = HALTED;
                  done_d  = 1'b1;
               end else if (BranchEn && BranchAbs) begin
                  pc_d = Target;
               end else if (BranchEn) begin
                  pc_d = pc_q + Target;
               end else begin
                  pc_d = pc_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef FETCH_RETIRE_COUNT_EN
   logic [15:0] cnt_q, cnt_d;

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Halt word retires too, so the count advances on every unstalled RUN cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q != RUN) begin
         if (Start) begin
            cnt_d = 16'd0;
         end
      end else if (!Stall && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   assign RetireCount = cnt_q;
`endif

   assign InstAddress = pc_q;
   assign InstOut     = InstIn;
   assign Done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
//  Module   : tb_fetch_sequencer
//  Brief    : Self-checking bench for fetch_sequencer against a behavioural
//             program-execution model driven by directed and random stimulus.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

   localparam int A        = 12;
   localparam int W        = 10;
   localparam int START_PC = 0;
   localparam int DEPTH    = 1 << A;

   logic         CLK = 1'b0;
   logic         Reset_n = 1'b0;
   logic         Start = 1'b0;
   logic         Stall = 1'b0;
   logic         BranchEn = 1'b0;
   logic         BranchAbs = 1'b0;
   logic [A-1:0] Target = '0;
   logic [W-1:0] InstIn;
   logic [A-1:0] InstAddress;
   logic [W-1:0] InstOut;
   logic         InstValid;
   logic         Done;
`ifdef FETCH_RETIRE_COUNT_EN
   logic [15:0]  RetireCount;
`endif

   logic [W-1:0] rom [0:DEPTH-1];
   assign InstIn = rom[InstAddress];

   fetch_sequencer #(.A(A), .W(W), .START_PC(START_PC)) dut (
      .CLK         (CLK),
      .Reset_n     (Reset_n),
      .Start       (Start),
      .Stall       (Stall),
      .BranchEn    (BranchEn),
      .BranchAbs   (BranchAbs),
      .Target      (Target),
      .InstIn      (InstIn),
      .InstAddress (InstAddress),
      .InstOut     (InstOut),
      .InstValid   (InstValid),
      .Done        (Done)
`ifdef FETCH_RETIRE_COUNT_EN
      ,
      .RetireCount (RetireCount)
`endif
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: running flag, halted flag, PC as an integer, retire count.
   bit m_running;
   bit m_done;
   int m_pc;
   int m_cnt;

   task automatic model_reset();
      m_running = 0;
      m_done    = 0;
      m_pc      = START_PC;
      m_cnt     = 0;
   endtask

   task automatic model_step();
      int off;
      if (!m_running) begin
         if (Start) begin
            m_running = 1;
            m_done    = 0;
            m_pc      = START_PC;
            m_cnt     = 0;
         end
      end else if (!Stall) begin
         if (m_cnt < 65535) m_cnt = m_cnt + 1;
         if (rom[m_pc] == {W{1'b1}}) begin
            m_running = 0;
            m_done    = 1;
         end else if (BranchEn && BranchAbs) begin
            m_pc = int'(Target);
         end else if (BranchEn) begin
            off  = Target[A-1] ? int'(Target) - DEPTH : int'(Target);
            m_pc = (m_pc + off + DEPTH) % DEPTH;
         end else begin
            m_pc = (m_pc + 1) % DEPTH;
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic st, input logic sl, input logic be,
                        input logic ba, input logic [A-1:0] tg);
      Start = st; Stall = sl; BranchEn = be; BranchAbs = ba; Target = tg;
      #1;
   endtask

   task automatic rom_clear();
      for (int i = 0; i < DEPTH; i++) rom[i] = '0;
   endtask

   task automatic do_reset();
      Reset_n = 1'b0;
      model_reset();
      #2;
      Reset_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      model_reset();
      rom_clear();
      #1;
      n_checks++;
      if (InstAddress !== A'(START_PC)) begin
         n_fail++; $display("FAIL reset_addr: got %h want %h", InstAddress, A'(START_PC));
      end
      n_checks++;
      if (InstValid !== 1'b0 || Done !== 1'b0) begin
         n_fail++; $display("FAIL reset_flags: valid %b done %b want 0 0", InstValid, Done);
      end
`ifdef FETCH_RETIRE_COUNT_EN
      n_checks++;
      if (RetireCount !== 16'd0) begin
         n_fail++; $display("FAIL reset_cnt: got %0d want 0", RetireCount);
      end
`endif
      #1 Reset_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic [A-1:0] exp_a;
      do_reset();
      rom_clear();
      rom[0] = 10'h001; rom[1] = 10'h049; rom[2] = 10'h081; rom[3] = 10'h3FF;
      drive(1, 0, 0, 0, '0);
      tick();
      drive(0, 0, 0, 0, '0);
      for (int i = 0; i < 4; i++) begin
         exp_a = A'(i);
         n_checks++;
         if (InstAddress !== exp_a || InstValid !== 1'b1 || InstOut !== rom[i]) begin
            n_fail++;
            $display("FAIL basic_fetch[%0d]: addr %h valid %b inst %h want %h 1 %h",
                     i, InstAddress, InstValid, InstOut, exp_a, rom[i]);
         end
         tick();
      end
      n_checks++;
      if (Done !== 1'b1 || InstAddress !== 12'h003 || InstValid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_halt: done %b addr %h valid %b want 1 003 0", Done, InstAddress, InstValid);
      end
`ifdef FETCH_RETIRE_COUNT_EN
      n_checks++;
      if (RetireCount !== 16'd4) begin
         n_fail++; $display("FAIL basic_cnt: got %0d want 4", RetireCount);
      end
`endif
   endtask

   task automatic test_restart();
      drive(1, 0, 0, 0, '0);
      n_checks++;
      if (Done !== 1'b1) begin
         n_fail++; $display("FAIL restart_pre_done: got %b want 1", Done);
      end
      tick();
      drive(0, 0, 0, 0, '0);
      n_checks++;
      if (Done !== 1'b0 || InstAddress !== A'(START_PC) || InstValid !== 1'b1) begin
         n_fail++;
         $display("FAIL restart: done %b addr %h valid %b want 0 %h 1", Done, InstAddress, InstValid, A'(START_PC));
      end
`ifdef FETCH_RETIRE_COUNT_EN
      n_checks++;
      if (RetireCount !== 16'd0) begin
         n_fail++; $display("FAIL restart_cnt: got %0d want 0", RetireCount);
      end
`endif
      tick();
      drive(1, 0, 0, 0, '0);
      tick();
      drive(0, 0, 0, 0, '0);
      n_checks++;
      if (InstAddress !== 12'h002 || Done !== 1'b0) begin
         n_fail++; $display("FAIL start_in_run: addr %h done %b want 002 0", InstAddress, Done);
      end
      tick();
      tick();
   endtask

   task automatic test_branch();
      do_reset();
      rom_clear();
      drive(1, 0, 0, 0, '0);
      tick();
      drive(0, 0, 0, 0, '0);
      repeat (3) tick();
      drive(0, 0, 1, 1, 12'h001);
      tick();
      n_checks++;
      if (InstAddress !== 12'h001) begin
         n_fail++; $display("FAIL branch_abs: got %h want 001", InstAddress);
      end
      drive(0, 0, 0, 0, '0);
      repeat (4) tick();
      drive(0, 0, 1, 0, 12'hFFE);
      tick();
      n_checks++;
      if (InstAddress !== 12'h003) begin
         n_fail++; $display("FAIL branch_rel_neg: got %h want 003", InstAddress);
      end
   endtask

   task automatic test_wrap();
      drive(0, 0, 1, 1, 12'hFFF);
      tick();
      drive(0, 0, 0, 0, '0);
      tick();
      n_checks++;
      if (InstAddress !== 12'h000) begin
         n_fail++; $display("FAIL wrap_inc: got %h want 000", InstAddress);
      end
      drive(0, 0, 1, 1, 12'hFFF);
      tick();
      drive(0, 0, 1, 0, 12'h002);
      tick();
      n_checks++;
      if (InstAddress !== 12'h001) begin
         n_fail++; $display("FAIL wrap_rel: got %h want 001", InstAddress);
      end
      drive(0, 0, 0, 0, '0);
   endtask

   task automatic test_stall();
      do_reset();
      rom_clear();
      rom[2] = {W{1'b1}};
      drive(1, 0, 0, 0, '0);
      tick();
      drive(0, 0, 0, 0, '0);
      repeat (2) tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 1, 1, 12'h005);
         n_checks++;
         if (InstAddress !== 12'h002 || InstValid !== 1'b0 || Done !== 1'b0) begin
            n_fail++;
            $display("FAIL stall[%0d]: addr %h valid %b done %b want 002 0 0", i, InstAddress, InstValid, Done);
         end
`ifdef FETCH_RETIRE_COUNT_EN
         n_checks++;
         if (RetireCount !== 16'd2) begin
            n_fail++; $display("FAIL stall_cnt[%0d]: got %0d want 2", i, RetireCount);
         end
`endif
         tick();
      end
      drive(0, 0, 1, 1, 12'h005);
      n_checks++;
      if (InstValid !== 1'b1) begin
         n_fail++; $display("FAIL unstall_valid: got %b want 1", InstValid);
      end
      tick();
      n_checks++;
      if (Done !== 1'b1 || InstAddress !== 12'h002) begin
         n_fail++; $display("FAIL stall_halt: done %b addr %h want 1 002", Done, InstAddress);
      end
      // Start beats Stall when leaving HALTED; the stall then holds the first RUN cycle.
      drive(1, 1, 0, 0, '0);
      tick();
      drive(0, 1, 0, 0, '0);
      n_checks++;
      if (Done !== 1'b0 || InstAddress !== A'(START_PC) || InstValid !== 1'b0) begin
         n_fail++;
         $display("FAIL start_stall: done %b addr %h valid %b want 0 %h 0", Done, InstAddress, InstValid, A'(START_PC));
      end
      drive(0, 0, 0, 0, '0);
   endtask

   task automatic test_async_reset();
      do_reset();
      rom_clear();
      drive(1, 0, 0, 0, '0);
      tick();
      drive(0, 0, 0, 0, '0);
      repeat (7) tick();
      n_checks++;
      if (InstAddress !== 12'h007 || InstValid !== 1'b1) begin
         n_fail++; $display("FAIL pre_reset: addr %h valid %b want 007 1", InstAddress, InstValid);
      end
      Reset_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (InstAddress !== A'(START_PC) || InstValid !== 1'b0 || Done !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: addr %h valid %b done %b want %h 0 0", InstAddress, InstValid, Done, A'(START_PC));
      end
      #1 Reset_n = 1'b1;
      tick();
      n_checks++;
      if (InstAddress !== A'(START_PC) || InstValid !== 1'b0) begin
         n_fail++; $display("FAIL idle_after_reset: addr %h valid %b want %h 0", InstAddress, InstValid, A'(START_PC));
      end
   endtask

   task automatic test_random();
      logic         exp_v;
      logic [A-1:0] exp_a;
      do_reset();
      for (int i = 0; i < DEPTH; i++)
         rom[i] = ($urandom_range(0, 19) == 0) ? {W{1'b1}} : W'($urandom_range(0, (1 << W) - 2));
      for (int c = 0; c < 400; c++) begin
         drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
               1'($urandom), A'($urandom));
         exp_v = m_running && !Stall;
         exp_a = m_pc[A-1:0];
         n_checks++;
         if (InstAddress !== exp_a || InstValid !== exp_v || Done !== m_done || InstOut !== rom[exp_a]) begin
            n_fail++;
            $display("FAIL random[%0d]: addr %h valid %b done %b inst %h want %h %b %b %h",
                     c, InstAddress, InstValid, Done, InstOut, exp_a, exp_v, m_done, rom[exp_a]);
         end
`ifdef FETCH_RETIRE_COUNT_EN
         n_checks++;
         if (RetireCount !== 16'(m_cnt)) begin
            n_fail++; $display("FAIL random_cnt[%0d]: got %0d want %0d", c, RetireCount, m_cnt);
         end
`endif
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_restart();
      test_branch();
      test_wrap();
      test_stall();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
